// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signal bundle for the direct-mapped instruction cache.
// The slave modport is the cache view; the master modport is the fetch/memory view.
interface icache_direct_if #(
    parameter int ADDR_WIDTH = 32
);
    // fetch unit <-> cache
    logic                  if2cache_en;
    logic [ADDR_WIDTH-1:0] if2cache_pc;
    logic                  cache2if_rdy;
    logic [31:0]           cache2if_inst;
    logic                  cache_busy;

    // cache <-> memory controller
    logic                  cache2mem_upd_en;
    logic [ADDR_WIDTH-1:0] cache2mem_PC;
    logic                  mem_busy;
    logic                  mem_rdy;
    logic [31:0]           mem2if_inst_out;

    modport slave (
        input  if2cache_en,
        input  if2cache_pc,
        output cache2if_rdy,
        output cache2if_inst,
        output cache_busy,
        output cache2mem_upd_en,
        output cache2mem_PC,
        input  mem_busy,
        input  mem_rdy,
        input  mem2if_inst_out
    );

    modport master (
        output if2cache_en,
        output if2cache_pc,
        input  cache2if_rdy,
        input  cache2if_inst,
        input  cache_busy,
        input  cache2mem_upd_en,
        input  cache2mem_PC,
        output mem_busy,
        output mem_rdy,
        output mem2if_inst_out
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Hits answer one cycle after the request; misses issue a single-word fill to
// the memory controller and answer on the fill completion edge. A flush cancels
// the pending answer but never aborts a fill already issued.
module icache_direct #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 4,
    parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    icache_direct_if.slave   bus
);
    localparam int LINES = 1 << INDEX_WIDTH;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state, state_next;

    // storage
    logic [LINES-1:0]     valid;
    logic [TAG_WIDTH-1:0] tag_arr  [LINES];
    logic [31:0]          data_arr [LINES];

    // registered outputs and fill bookkeeping
    logic                  rdy_q,     rdy_d;
    logic [31:0]           inst_q,    inst_d;
    logic                  upd_en_q,  upd_en_d;
    logic [ADDR_WIDTH-3:0] fill_pc_q, fill_pc_d;
    logic                  seen_busy, seen_busy_d;
    logic                  drop,      drop_d;
    logic                  fill_we;

    // request address decode
    logic [INDEX_WIDTH-1:0] req_idx;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic                   req_hit;
    logic                   pc_lsb_unused;

    // fill address decode (word address held for the whole fill)
    logic [INDEX_WIDTH-1:0] fill_idx;
    logic [TAG_WIDTH-1:0]   fill_tag;
    logic                   fill_done;

    assign req_idx       = bus.if2cache_pc[INDEX_WIDTH+1:2];
    assign req_tag       = bus.if2cache_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign req_hit       = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign pc_lsb_unused = ^bus.if2cache_pc[1:0];

    assign fill_idx  = fill_pc_q[INDEX_WIDTH-1:0];
    assign fill_tag  = fill_pc_q[ADDR_WIDTH-3:INDEX_WIDTH];
    // mem_rdy idles high after reset, so it only counts once memory has shown busy
    assign fill_done = (seen_busy || bus.mem_busy) && bus.mem_rdy;

    assign bus.cache2if_rdy     = rdy_q;
    assign bus.cache2if_inst    = inst_q;
    assign bus.cache_busy       = (state != IDLE);
    assign bus.cache2mem_upd_en = upd_en_q;
    assign bus.cache2mem_PC     = {fill_pc_q, 2'b00};

    // next-state and next-output logic
    always_comb begin
        state_next  = state;
        rdy_d       = 1'b0;
        inst_d      = inst_q;
        upd_en_d    = upd_en_q;
        fill_pc_d   = fill_pc_q;
        seen_busy_d = seen_busy;
        drop_d      = drop;
        fill_we     = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.if2cache_en && !flush) begin
                    if (req_hit) begin
                        rdy_d  = 1'b1;
                        inst_d = data_arr[req_idx];
                    end else begin
                        fill_pc_d   = bus.if2cache_pc[ADDR_WIDTH-1:2];
                        upd_en_d    = 1'b1;
                        seen_busy_d = 1'b0;
                        drop_d      = 1'b0;
                        state_next  = FILL;
                    end
                end
            end
            FILL: begin
                if (bus.mem_busy) begin
                    seen_busy_d = 1'b1;
                end
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (fill_done) begin
                    fill_we    = 1'b1;
                    upd_en_d   = 1'b0;
                    state_next = IDLE;
                    if (!drop && !flush) begin
                        rdy_d  = 1'b1;
                        inst_d = bus.mem2if_inst_out;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // state register; everything holds while rdy_in is low
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_next;
        end
    end

    // output and fill-tracking registers
    always_ff @(posedge clk) begin
        if (rst_in) begin
            rdy_q     <= 1'b0;
            inst_q    <= '0;
            upd_en_q  <= 1'b0;
            fill_pc_q <= '0;
            seen_busy <= 1'b0;
            drop      <= 1'b0;
        end else if (rdy_in) begin
            rdy_q     <= rdy_d;
            inst_q    <= inst_d;
            upd_en_q  <= upd_en_d;
            fill_pc_q <= fill_pc_d;
            seen_busy <= seen_busy_d;
            drop      <= drop_d;
        end
    end

    // valid bits; reset invalidates every line and discards any fill in flight
    always_ff @(posedge clk) begin
        if (rst_in) begin
            valid <= '0;
        end else if (rdy_in && fill_we) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    // data and tag arrays; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (!rst_in && rdy_in && fill_we) begin
            data_arr[fill_idx] <= bus.mem2if_inst_out;
            tag_arr[fill_idx]  <= fill_tag;
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: expected instructions are queued when the
// stimulus makes an answer due and popped when the cache pulses cache2if_rdy.
module tb_icache_direct;
    logic clk = 1'b0;
    logic rst_in, rdy_in, flush;

    icache_direct_if #(.ADDR_WIDTH(32)) bus ();

    icache_direct #(
        .ADDR_WIDTH (32),
        .INDEX_WIDTH(4)
    ) dut (
        .clk   (clk),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // a pulse is consumed at the edge where rdy_in is high, so count it once there
    always @(negedge clk) begin
        if (rdy_in && bus.cache2if_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                check_eq("sb_inst", bus.cache2if_inst, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_idle();
        bus.mem_busy        = 1'b0;
        bus.mem_rdy         = 1'b1;
        bus.mem2if_inst_out = 32'hDEAD_BEEF;
    endtask

    task automatic request(input logic [31:0] pc);
        bus.if2cache_en = 1'b1;
        bus.if2cache_pc = pc;
        tick();
        bus.if2cache_en = 1'b0;
    endtask

    // memory busy for n cycles, then strobes mem_rdy with word; flush pulsed on busy cycle flush_at
    task automatic mem_fill(input int n, input logic [31:0] word, input bit deliver, input int flush_at);
        for (int i = 0; i < n; i++) begin
            bus.mem_busy = 1'b1;
            bus.mem_rdy  = 1'b0;
            flush        = (i == flush_at);
            tick();
        end
        flush               = 1'b0;
        bus.mem_busy        = 1'b0;
        bus.mem_rdy         = 1'b1;
        bus.mem2if_inst_out = word;
        if (deliver) exp_q.push_back(word);
        tick();
        mem_idle();
        check_eq("done_rdy", {31'd0, bus.cache2if_rdy}, {31'd0, deliver});
        if (deliver) check_eq("done_inst", bus.cache2if_inst, word);
        check_eq("done_upd", {31'd0, bus.cache2mem_upd_en}, 32'd0);
        check_eq("done_busy", {31'd0, bus.cache_busy}, 32'd0);
        tick();
        check_eq("pulse_end", {31'd0, bus.cache2if_rdy}, 32'd0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic expect_miss(input string tag, input logic [31:0] pc);
        check_eq({tag, "_busy"}, {31'd0, bus.cache_busy}, 32'd1);
        check_eq({tag, "_upd"}, {31'd0, bus.cache2mem_upd_en}, 32'd1);
        check_eq({tag, "_pc"}, bus.cache2mem_PC, {pc[31:2], 2'b00});
        check_eq({tag, "_rdy"}, {31'd0, bus.cache2if_rdy}, 32'd0);
    endtask

    task automatic hit(input string tag, input logic [31:0] pc, input logic [31:0] word);
        exp_q.push_back(word);
        request(pc);
        check_eq({tag, "_rdy"}, {31'd0, bus.cache2if_rdy}, 32'd1);
        check_eq({tag, "_inst"}, bus.cache2if_inst, word);
        check_eq({tag, "_upd"}, {31'd0, bus.cache2mem_upd_en}, 32'd0);
        tick();
        check_eq({tag, "_end"}, {31'd0, bus.cache2if_rdy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in          = 1'b1;
        rdy_in          = 1'b1;
        flush           = 1'b0;
        bus.if2cache_en = 1'b0;
        bus.if2cache_pc = '0;
        mem_idle();
        do_reset();

        // reset state
        check_eq("rst_rdy", {31'd0, bus.cache2if_rdy}, 32'd0);
        check_eq("rst_inst", bus.cache2if_inst, 32'd0);
        check_eq("rst_upd", {31'd0, bus.cache2mem_upd_en}, 32'd0);
        check_eq("rst_pc", bus.cache2mem_PC, 32'd0);
        check_eq("rst_busy", {31'd0, bus.cache_busy}, 32'd0);

        // cold miss then hit
        request(32'h0000_0010);
        expect_miss("miss10", 32'h10);
        mem_fill(4, 32'h0051_0513, 1'b1, -1);
        hit("hit10", 32'h10, 32'h0051_0513);

        // same-cycle flush ignores a request that would hit
        bus.if2cache_en = 1'b1;
        bus.if2cache_pc = 32'h10;
        flush           = 1'b1;
        tick();
        bus.if2cache_en = 1'b0;
        flush           = 1'b0;
        check_eq("flreq_rdy", {31'd0, bus.cache2if_rdy}, 32'd0);
        check_eq("flreq_busy", {31'd0, bus.cache_busy}, 32'd0);

        // alias at index 4 evicts 0x10
        request(32'h0000_0110);
        expect_miss("alias", 32'h110);
        mem_fill(3, 32'hFFF0_0093, 1'b1, -1);
        hit("hit110", 32'h110, 32'hFFF0_0093);
        request(32'h0000_0010);
        expect_miss("evict", 32'h10);
        mem_fill(2, 32'h0051_0513, 1'b1, -1);

        // flush during fill: line written, no answer
        request(32'h0000_0020);
        expect_miss("miss20", 32'h20);
        mem_fill(4, 32'h00A0_0113, 1'b0, 1);
        hit("hit20", 32'h20, 32'h00A0_0113);

        // idle mem_rdy before memory shows busy must not complete the fill
        do_reset();
        request(32'h0000_0010);
        expect_miss("postrst", 32'h10);
        for (int i = 0; i < 3; i++) tick();
        expect_miss("rdyidle", 32'h10);
        mem_fill(4, 32'h0051_0513, 1'b1, -1);

        // rdy_in low during FILL: everything frozen even with a completing strobe
        request(32'h0000_0030);
        expect_miss("miss30", 32'h30);
        bus.mem_busy = 1'b1;
        bus.mem_rdy  = 1'b0;
        tick();
        tick();
        rdy_in              = 1'b0;
        bus.mem_busy        = 1'b0;
        bus.mem_rdy         = 1'b1;
        bus.mem2if_inst_out = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_miss("frz_fill", 32'h30);
        end
        rdy_in = 1'b1;
        mem_fill(2, 32'h1234_5678, 1'b1, -1);

        // rdy_in low during a rdy pulse: pulse and data stretched
        exp_q.push_back(32'h1234_5678);
        request(32'h30);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("frz_rdy", {31'd0, bus.cache2if_rdy}, 32'd1);
            check_eq("frz_inst", bus.cache2if_inst, 32'h1234_5678);
        end
        rdy_in = 1'b1;
        tick();
        check_eq("frz_end", {31'd0, bus.cache2if_rdy}, 32'd0);

        // reset mid-fill abandons the fill and invalidates everything
        request(32'h0000_0040);
        expect_miss("miss40", 32'h40);
        bus.mem_busy = 1'b1;
        bus.mem_rdy  = 1'b0;
        tick();
        tick();
        mem_idle();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check_eq("midrst_upd", {31'd0, bus.cache2mem_upd_en}, 32'd0);
        check_eq("midrst_busy", {31'd0, bus.cache_busy}, 32'd0);
        request(32'h0000_0010);
        expect_miss("remiss10", 32'h10);
        mem_fill(3, 32'h0051_0513, 1'b1, -1);
        request(32'h0000_0040);
        expect_miss("remiss40", 32'h40);
        mem_fill(2, 32'h0000_0073, 1'b1, -1);

        tick();
        check_eq("sb_drain", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
